// File: rtl/pio_gen_debounce.sv
// Avalon-MM GPIO: synchronised, debounced, edge-capturing inputs with a
// maskable level interrupt, plus an output register with atomic set/clear.

// One input bit: two-flop synchroniser followed by a stability counter.
module pio_gen_debounce_lane #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic db_o
);
    // The counter never needs to hold DEBOUNCE_CYCLES itself, but the width
    // must stay legal when the stage is bypassed.
    localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    logic          s1_q, s2_q;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Synchroniser, debounced state and counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            s1_q  <= pin_i;
            s2_q  <= s1_q;
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    // Any cycle where the input agrees with db restarts the count, so only an
    // uninterrupted run of DEBOUNCE_CYCLES disagreeing samples flips db.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (DEBOUNCE_CYCLES == 0) begin
            db_d = s2_q;
        end else if (s2_q != db_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                db_d  = s2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign db_o = db_q;
endmodule

module pio_gen_debounce #(
    parameter int              WIDTH           = 10,
    parameter int              DEBOUNCE_CYCLES = 16,
    parameter int              EDGE_MODE       = 0,
    parameter logic [WIDTH-1:0] OUT_RESET      = '0
) (
    input  logic             clk_50,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port
);
    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] db_dly_q;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] rise, fall, evt, wv;
    logic             wr_en, rd_en;

    // Upper write-data bits beyond WIDTH have no destination.
    wire unused_wd = &{1'b0, writedata};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_lane
            pio_gen_debounce_lane #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_lane (
                .clk_i (clk_50),
                .rst_i (reset),
                .pin_i (in_port[gi]),
                .db_o  (db[gi])
            );
        end
    endgenerate

    assign wr_en = chipselect & write;
    assign rd_en = chipselect & read;
    assign wv    = writedata[WIDTH-1:0];

    // Register file next state; reads use current values, so a same-cycle
    // write is not visible until the following read.
    always_comb begin
        rise = db & ~db_dly_q;
        fall = ~db & db_dly_q;
        case (EDGE_MODE)
            0:       evt = rise;
            1:       evt = fall;
            default: evt = rise | fall;
        endcase

        edge_cap_d = edge_cap_q;
        irq_mask_d = irq_mask_q;
        out_d      = out_q;
        readdata_d = '0;

        if (wr_en) begin
            case (address)
                3'd1:    out_d      = wv;
                3'd2:    irq_mask_d = wv;
                3'd3:    edge_cap_d = edge_cap_q & ~wv;
                3'd4:    out_d      = out_q | wv;
                3'd5:    out_d      = out_q & ~wv;
                default: ;
            endcase
        end
        // New events are OR-ed in after the W1C so a coincident edge survives.
        edge_cap_d = edge_cap_d | evt;

        if (rd_en) begin
            case (address)
                3'd0:    readdata_d = 32'(db);
                3'd1:    readdata_d = 32'(out_q);
                3'd2:    readdata_d = 32'(irq_mask_q);
                3'd3:    readdata_d = 32'(edge_cap_q);
                default: readdata_d = '0;
            endcase
        end

        irq_d = |(edge_cap_q & irq_mask_q);
    end

    // Register-file state.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            db_dly_q   <= '0;
            edge_cap_q <= '0;
            irq_mask_q <= '0;
            out_q      <= OUT_RESET;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            db_dly_q   <= db;
            edge_cap_q <= edge_cap_d;
            irq_mask_q <= irq_mask_d;
            out_q      <= out_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;
    assign out_port = out_q;
endmodule

// File: tb/tb_pio_gen_debounce.sv
// Four instances share one bus and pin set: debounce 4 with rising, falling
// and any-edge capture, plus a bypassed-debounce instance. A pin-history
// model predicts every output after every clock edge.
module tb_pio_gen_debounce;
    localparam int NI = 4;

    logic        clk_50 = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0, read = 1'b0, write = 1'b0;
    logic [31:0] writedata = '0;
    logic [9:0]  in_port = '0;
    logic [31:0] rdata [NI];
    logic        irqv  [NI];
    logic [9:0]  outp  [NI];

    int n_assert = 0;
    int n_fail   = 0;

    always #10 clk_50 = ~clk_50;

    pio_gen_debounce #(.WIDTH(10), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0), .OUT_RESET(10'h000)) u0 (
        .clk_50(clk_50), .reset(reset), .address(address), .chipselect(chipselect), .read(read),
        .write(write), .writedata(writedata), .readdata(rdata[0]), .irq(irqv[0]),
        .in_port(in_port), .out_port(outp[0]));
    pio_gen_debounce #(.WIDTH(10), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1), .OUT_RESET(10'h000)) u1 (
        .clk_50(clk_50), .reset(reset), .address(address), .chipselect(chipselect), .read(read),
        .write(write), .writedata(writedata), .readdata(rdata[1]), .irq(irqv[1]),
        .in_port(in_port), .out_port(outp[1]));
    pio_gen_debounce #(.WIDTH(10), .DEBOUNCE_CYCLES(4), .EDGE_MODE(2), .OUT_RESET(10'h000)) u2 (
        .clk_50(clk_50), .reset(reset), .address(address), .chipselect(chipselect), .read(read),
        .write(write), .writedata(writedata), .readdata(rdata[2]), .irq(irqv[2]),
        .in_port(in_port), .out_port(outp[2]));
    pio_gen_debounce #(.WIDTH(10), .DEBOUNCE_CYCLES(0), .EDGE_MODE(0), .OUT_RESET(10'h000)) u3 (
        .clk_50(clk_50), .reset(reset), .address(address), .chipselect(chipselect), .read(read),
        .write(write), .writedata(writedata), .readdata(rdata[3]), .irq(irqv[3]),
        .in_port(in_port), .out_port(outp[3]));

    // Reference model state
    logic [9:0]  ph [8];               // ph[0] = most recent pin sample
    logic [9:0]  m_db [NI], m_dbd [NI], m_cap [NI], m_mask [NI], m_out [NI];
    logic        m_irq [NI];
    logic [31:0] m_rd [NI];

    function automatic int dbc(int c);
        return (c == 3) ? 0 : 4;
    endfunction
    function automatic int emode(int c);
        return (c < 3) ? c : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model across one clock edge given the inputs seen there.
    task automatic model_step(input logic rst, input logic [9:0] pin, input logic cs,
                              input logic rd, input logic wr, input logic [2:0] a,
                              input logic [31:0] wd);
        logic [9:0] ev, nd, wv;
        if (rst) begin
            for (int j = 0; j < 8; j++) ph[j] = '0;
            for (int c = 0; c < NI; c++) begin
                m_db[c] = '0; m_dbd[c] = '0; m_cap[c] = '0; m_mask[c] = '0;
                m_out[c] = '0; m_irq[c] = 1'b0; m_rd[c] = '0;
            end
            return;
        end
        wv = wd[9:0];
        for (int c = 0; c < NI; c++) begin
            m_rd[c] = '0;
            if (cs && rd) begin
                case (a)
                    3'd0: m_rd[c] = 32'(m_db[c]);
                    3'd1: m_rd[c] = 32'(m_out[c]);
                    3'd2: m_rd[c] = 32'(m_mask[c]);
                    3'd3: m_rd[c] = 32'(m_cap[c]);
                    default: m_rd[c] = '0;
                endcase
            end
            case (emode(c))
                0: ev = m_db[c] & ~m_dbd[c];
                1: ev = ~m_db[c] & m_dbd[c];
                default: ev = m_db[c] ^ m_dbd[c];
            endcase
            m_irq[c] = |(m_cap[c] & m_mask[c]);
            if (cs && wr && a == 3'd3) m_cap[c] = m_cap[c] & ~wv;
            m_cap[c] = m_cap[c] | ev;
            if (cs && wr) begin
                case (a)
                    3'd1: m_out[c] = wv;
                    3'd2: m_mask[c] = wv;
                    3'd4: m_out[c] = m_out[c] | wv;
                    3'd5: m_out[c] = m_out[c] & ~wv;
                    default: ;
                endcase
            end
            // The synchronised view of the pins lags sampling by one edge, so
            // the samples visible here are ph[1..D]; db flips once all of them
            // disagree with it.
            nd = m_db[c];
            if (dbc(c) == 0) nd = ph[1];
            else begin
                for (int i = 0; i < 10; i++) begin
                    logic all_diff;
                    all_diff = 1'b1;
                    for (int j = 1; j <= dbc(c); j++)
                        if (ph[j][i] == m_db[c][i]) all_diff = 1'b0;
                    if (all_diff) nd[i] = ~m_db[c][i];
                end
            end
            m_dbd[c] = m_db[c];
            m_db[c]  = nd;
        end
        for (int j = 7; j > 0; j--) ph[j] = ph[j-1];
        ph[0] = pin;
    endtask

    task automatic tick();
        logic r, c, rd, wr;
        logic [2:0] a;
        logic [31:0] wd;
        logic [9:0] p;
        r = reset; c = chipselect; rd = read; wr = write; a = address; wd = writedata; p = in_port;
        @(posedge clk_50);
        model_step(r, p, c, rd, wr, a, wd);
        #1;
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("out_port[u%0d]", k), 32'(outp[k]), 32'(m_out[k]));
            chk($sformatf("irq[u%0d]", k), 32'(irqv[k]), 32'(m_irq[k]));
            chk($sformatf("readdata[u%0d]", k), rdata[k], m_rd[k]);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic idle();
        chipselect = 1'b0; read = 1'b0; write = 1'b0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
        tick();
        idle();
    endtask

    task automatic bus_read(input logic [2:0] a);
        chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
        tick();
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, cap_t, irq_t;
        bit found;

        // Reset
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        chk("reset_out_port", 32'(outp[0]), 32'h000);
        chk("reset_irq", 32'(irqv[0]), 32'h0);
        for (int a = 0; a < 6; a++) begin
            bus_read(3'(a));
            chk($sformatf("reset_read_a%0d", a), rdata[0], 32'h0);
        end

        // Debounce latency: db at 6 edges, visible through readdata one later
        in_port[3] = 1'b1;
        chipselect = 1'b1; read = 1'b1; address = 3'd0;
        lat = 0; found = 0;
        for (int n = 1; n <= 20 && !found; n++) begin
            tick();
            if (rdata[0][3]) begin lat = n; found = 1; end
        end
        idle();
        chk("db_latency", 32'(lat), 32'd7);

        // Short pulse is filtered
        bus_write(3'd3, 32'h3FF);
        in_port[5] = 1'b1; ticks(3); in_port[5] = 1'b0; ticks(10);
        bus_read(3'd0);
        chk("glitch_data_in_b5", 32'(rdata[0][5]), 32'h0);
        bus_read(3'd3);
        chk("glitch_edge_cap", rdata[0], 32'h0);

        // Edge capture and irq
        in_port[3] = 1'b0; ticks(10);
        bus_write(3'd2, 32'h008);
        bus_write(3'd3, 32'h3FF);
        in_port[3] = 1'b1;
        chipselect = 1'b1; read = 1'b1; address = 3'd3;
        cap_t = 0; irq_t = 0;
        for (int n = 1; n <= 20 && (cap_t == 0 || irq_t == 0); n++) begin
            tick();
            if (cap_t == 0 && rdata[0] == 32'h008) cap_t = n;
            if (irq_t == 0 && irqv[0]) irq_t = n;
        end
        idle();
        chk("edge_cap_seen", 32'(cap_t != 0), 32'h1);
        chk("irq_one_after_cap", 32'(irq_t), 32'(cap_t));

        // W1C drops irq one cycle after the write
        bus_write(3'd3, 32'h008);
        chk("irq_at_w1c_edge", 32'(irqv[0]), 32'h1);
        tick();
        chk("irq_after_w1c", 32'(irqv[0]), 32'h0);

        // Output set / clear
        bus_write(3'd1, 32'h0F0);
        chk("out_data", 32'(outp[0]), 32'h0F0);
        bus_write(3'd4, 32'h301);
        chk("out_set", 32'(outp[0]), 32'h3F1);
        bus_write(3'd5, 32'h0F0);
        chk("out_clr", 32'(outp[0]), 32'h301);
        bus_read(3'd4);
        chk("read_out_set", rdata[0], 32'h0);

        // W1C coinciding with a new edge: set wins
        in_port[2] = 1'b1;
        found = 0;
        for (int n = 0; n < 20 && !found; n++) begin
            if (m_db[0][2] && !m_dbd[0][2]) found = 1;
            else tick();
        end
        chk("collision_window_found", 32'(found), 32'h1);
        bus_write(3'd3, 32'h004);
        bus_read(3'd3);
        chk("collision_edge_cap", rdata[0], 32'h004);

        // Falling / any-edge modes on bit 0
        bus_write(3'd3, 32'h3FF);
        in_port[0] = 1'b1; ticks(10);
        bus_read(3'd3);
        chk("fall_mode_rise_b0", 32'(rdata[1][0]), 32'h0);
        chk("any_mode_rise_b0", 32'(rdata[2][0]), 32'h1);
        bus_write(3'd3, 32'h3FF);
        in_port[0] = 1'b0; ticks(10);
        bus_read(3'd3);
        chk("fall_mode_fall", rdata[1], 32'h001);
        chk("any_mode_fall_b0", 32'(rdata[2][0]), 32'h1);

        // Bypassed debounce: db after 3 edges, readdata one later
        in_port[7] = 1'b1;
        chipselect = 1'b1; read = 1'b1; address = 3'd0;
        lat = 0; found = 0;
        for (int n = 1; n <= 20 && !found; n++) begin
            tick();
            if (rdata[3][7]) begin lat = n; found = 1; end
        end
        idle();
        chk("bypass_latency", 32'(lat), 32'd4);

        // Randomised traffic against the model, with one reset mid-stream
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) in_port = in_port ^ (10'($urandom) & 10'($urandom));
            chipselect = ($urandom_range(3) != 0);
            read       = $urandom_range(1);
            write      = ($urandom_range(4) < 2);
            address    = 3'($urandom_range(7));
            writedata  = $urandom;
            reset      = (i == 200);
            tick();
        end
        reset = 1'b0;
        idle();
        ticks(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
